param_shift_pipe: RTL and testbench

//  Parametrised multi-stage shift register: DEPTH stages of WIDTH-bit words, each with a valid bit.

---
 rtl/shift_pipe_pkg.sv | 24 ++
 rtl/shift_pipe_stage.sv | 70 +++++++
 rtl/param_shift_pipe.sv | 162 ++++++++++++++++
 tb/tb_param_shift_pipe.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pipe_pkg.sv
// Shared definitions for the param_shift_pipe slice: mode encodings and popcount.
// Optional tap feature is selected with SHIFT_PIPE_TAP_EN (see param_shift_pipe).
package shift_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_FWD  = 2'b01,
    MODE_REV  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  // Upper bound on DEPTH that popcount can handle.
  localparam int unsigned POP_MAX = 64;

  function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < POP_MAX; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// One shift stage: WIDTH-bit word plus valid bit with hold/prev/next/load mux and sync clear.
// With SHIFT_PIPE_TAP_EN the post-edge (next) value is also exported for the tap.
module shift_pipe_stage
  import shift_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] prev_word,
  input  logic             prev_vld,
  input  logic [WIDTH-1:0] next_word,
  input  logic             next_vld,
  input  logic [WIDTH-1:0] load_word,
  input  logic             load_vld,
  output logic [WIDTH-1:0] word_q,
  output logic             vld_q
`ifdef SHIFT_PIPE_TAP_EN
  ,
  output logic [WIDTH-1:0] word_nxt,
  output logic             vld_nxt
`endif
);

  logic [WIDTH-1:0] word_d;
  logic             vld_d;

  always_comb begin
    word_d = word_q;
    vld_d  = vld_q;
    if (clr) begin
      word_d = '0;
      vld_d  = 1'b0;
    end else begin
      case (mode_e'(sel))
        MODE_FWD: begin
          word_d = prev_word;
          vld_d  = prev_vld;
        end
        MODE_REV: begin
          word_d = next_word;
          vld_d  = next_vld;
        end
        MODE_LOAD: begin
          word_d = load_word;
          vld_d  = load_vld;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      word_q <= word_d;
      vld_q  <= vld_d;
    end
  end

`ifdef SHIFT_PIPE_TAP_EN
  assign word_nxt = word_d;
  assign vld_nxt  = vld_d;
`endif

endmodule

// File: rtl/param_shift_pipe.sv
// DEPTH x WIDTH shift pipe with valid bits, occupancy counter and full/empty decodes.
// Define SHIFT_PIPE_TAP_EN to add the registered tap (tap_sel/tap_q/tap_vld).
module param_shift_pipe
  import shift_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic [1:0]               mode,
  input  logic [WIDTH-1:0]         din,
  input  logic                     din_vld,
  input  logic [WIDTH*DEPTH-1:0]   pdin,
  input  logic [DEPTH-1:0]         pvld,
  output logic [WIDTH-1:0]         q_fwd,
  output logic [WIDTH-1:0]         q_rev,
  output logic [WIDTH*DEPTH-1:0]   pq,
  output logic [DEPTH-1:0]         vld,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                     full,
  output logic                     empty
`ifdef SHIFT_PIPE_TAP_EN
  ,
  input  logic [$clog2(DEPTH)-1:0] tap_sel,
  output logic [WIDTH-1:0]         tap_q,
  output logic [0:0]               tap_vld
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] word_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [CW-1:0]    count_q, count_d;
  logic [POP_MAX-1:0] pvld_ext;

`ifdef SHIFT_PIPE_TAP_EN
  localparam int unsigned TSW = $clog2(DEPTH);
  logic [WIDTH-1:0] word_nxt [DEPTH];
  logic [DEPTH-1:0] vld_nxt;
  logic [WIDTH-1:0] tap_q_q, tap_q_d;
  logic             tap_vld_q, tap_vld_d;
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] prev_w, next_w;
    logic             prev_v, next_v;

    if (i == 0) begin : g_head
      assign prev_w = din;
      assign prev_v = din_vld;
    end else begin : g_head
      assign prev_w = word_q[i-1];
      assign prev_v = vld_q[i-1];
    end

    if (i == DEPTH - 1) begin : g_tail
      assign next_w = din;
      assign next_v = din_vld;
    end else begin : g_tail
      assign next_w = word_q[i+1];
      assign next_v = vld_q[i+1];
    end

    shift_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .sel       (mode),
      .prev_word (prev_w),
      .prev_vld  (prev_v),
      .next_word (next_w),
      .next_vld  (next_v),
      .load_word (pdin[i*WIDTH +: WIDTH]),
      .load_vld  (pvld[i]),
      .word_q    (word_q[i]),
      .vld_q     (vld_q[i])
`ifdef SHIFT_PIPE_TAP_EN
      ,
      .word_nxt  (word_nxt[i]),
      .vld_nxt   (vld_nxt[i])
`endif
    );
  end

  always_comb begin
    pvld_ext = '0;
    pvld_ext[DEPTH-1:0] = pvld;
  end

  // Shifting changes occupancy by at most one: the word entering vs the word falling off.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else begin
      case (mode_e'(mode))
        MODE_FWD: begin
          if (din_vld && !vld_q[DEPTH-1])      count_d = count_q + CW'(1);
          else if (!din_vld && vld_q[DEPTH-1]) count_d = count_q - CW'(1);
        end
        MODE_REV: begin
          if (din_vld && !vld_q[0])            count_d = count_q + CW'(1);
          else if (!din_vld && vld_q[0])       count_d = count_q - CW'(1);
        end
        MODE_LOAD: count_d = CW'(popcount(pvld_ext));
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  always_comb begin
    pq = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      pq[i*WIDTH +: WIDTH] = word_q[i];
    end
  end

  assign q_fwd = word_q[DEPTH-1];
  assign q_rev = word_q[0];
  assign vld   = vld_q;
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

`ifdef SHIFT_PIPE_TAP_EN
  // Tap samples the value each stage takes on this edge; out-of-range selects read as invalid zero.
  always_comb begin
    tap_q_d   = '0;
    tap_vld_d = 1'b0;
    if (!clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (tap_sel == TSW'(i)) begin
          tap_q_d   = word_nxt[i];
          tap_vld_d = vld_nxt[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tap_q_q   <= '0;
      tap_vld_q <= 1'b0;
    end else begin
      tap_q_q   <= tap_q_d;
      tap_vld_q <= tap_vld_d;
    end
  end

  assign tap_q      = tap_q_q;
  assign tap_vld[0] = tap_vld_q;
`endif

endmodule

// File: tb/tb_param_shift_pipe.sv
// Directed bench for param_shift_pipe: 2x2 and 4x4 instances (plus a 2x3 tap instance with SHIFT_PIPE_TAP_EN).
module tb_param_shift_pipe;
  import shift_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: WIDTH=2, DEPTH=2
  logic       a_clr, a_din_vld;
  logic [1:0] a_mode, a_din, a_pvld, a_q_fwd, a_q_rev, a_vld, a_count;
  logic [3:0] a_pdin, a_pq;
  logic       a_full, a_empty;

  // Instance B: WIDTH=4, DEPTH=4
  logic        b_clr, b_din_vld;
  logic [1:0]  b_mode;
  logic [3:0]  b_din, b_pvld, b_q_fwd, b_q_rev, b_vld;
  logic [15:0] b_pdin, b_pq;
  logic [2:0]  b_count;
  logic        b_full, b_empty;

`ifdef SHIFT_PIPE_TAP_EN
  logic [0:0] a_tap_sel, a_tap_vld, b_tap_vld, c_tap_vld;
  logic [1:0] a_tap_q, b_tap_sel, c_tap_sel, c_tap_q;
  logic [3:0] b_tap_q;
  logic       c_clr, c_din_vld, c_full, c_empty;
  logic [1:0] c_mode, c_din, c_q_fwd, c_q_rev, c_count;
  logic [2:0] c_pvld, c_vld;
  logic [5:0] c_pdin, c_pq;
`endif

  param_shift_pipe #(.WIDTH(2), .DEPTH(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .clr(a_clr), .mode(a_mode), .din(a_din), .din_vld(a_din_vld),
    .pdin(a_pdin), .pvld(a_pvld), .q_fwd(a_q_fwd), .q_rev(a_q_rev), .pq(a_pq), .vld(a_vld),
    .count(a_count), .full(a_full), .empty(a_empty)
`ifdef SHIFT_PIPE_TAP_EN
    , .tap_sel(a_tap_sel), .tap_q(a_tap_q), .tap_vld(a_tap_vld)
`endif
  );

  param_shift_pipe #(.WIDTH(4), .DEPTH(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .mode(b_mode), .din(b_din), .din_vld(b_din_vld),
    .pdin(b_pdin), .pvld(b_pvld), .q_fwd(b_q_fwd), .q_rev(b_q_rev), .pq(b_pq), .vld(b_vld),
    .count(b_count), .full(b_full), .empty(b_empty)
`ifdef SHIFT_PIPE_TAP_EN
    , .tap_sel(b_tap_sel), .tap_q(b_tap_q), .tap_vld(b_tap_vld)
`endif
  );

`ifdef SHIFT_PIPE_TAP_EN
  param_shift_pipe #(.WIDTH(2), .DEPTH(3)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .clr(c_clr), .mode(c_mode), .din(c_din), .din_vld(c_din_vld),
    .pdin(c_pdin), .pvld(c_pvld), .q_fwd(c_q_fwd), .q_rev(c_q_rev), .pq(c_pq), .vld(c_vld),
    .count(c_count), .full(c_full), .empty(c_empty),
    .tap_sel(c_tap_sel), .tap_q(c_tap_q), .tap_vld(c_tap_vld)
  );
`endif

  function automatic int pop(input logic [15:0] v);
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_mode = MODE_FWD; a_din = 2'd3; a_din_vld = 1'b1;
    b_mode = MODE_LOAD; b_pdin = 16'hFFFF; b_pvld = 4'hF;
    tick();
    rst_n = 1'b1; a_mode = MODE_HOLD; b_mode = MODE_HOLD;
    n_tests++; if (a_pq !== 4'h0)    begin n_fail++; $display("FAIL reset_a_pq: got %h exp 0", a_pq); end
    n_tests++; if (a_vld !== 2'b00)  begin n_fail++; $display("FAIL reset_a_vld: got %b exp 00", a_vld); end
    n_tests++; if (a_count !== 2'd0) begin n_fail++; $display("FAIL reset_a_count: got %0d exp 0", a_count); end
    n_tests++; if (a_empty !== 1'b1 || a_full !== 1'b0)
      begin n_fail++; $display("FAIL reset_a_flags: got empty=%b full=%b exp 1 0", a_empty, a_full); end
    n_tests++; if (b_pq !== 16'h0 || b_count !== 3'd0 || b_empty !== 1'b1)
      begin n_fail++; $display("FAIL reset_b: got pq=%h count=%0d empty=%b exp 0 0 1", b_pq, b_count, b_empty); end
  endtask

  task automatic test_fwd_latency();
    a_mode = MODE_FWD; a_din = 2'd3; a_din_vld = 1'b1;
    tick();
    n_tests++; if (a_pq !== 4'b0011) begin n_fail++; $display("FAIL fwd_e1_pq: got %b exp 0011", a_pq); end
    n_tests++; if (a_q_fwd !== 2'd0) begin n_fail++; $display("FAIL fwd_e1_qfwd: got %0d exp 0", a_q_fwd); end
    n_tests++; if (a_count !== 2'd1 || a_vld !== 2'b01)
      begin n_fail++; $display("FAIL fwd_e1_cnt: got count=%0d vld=%b exp 1 01", a_count, a_vld); end
    a_din = 2'd0;
    tick();
    n_tests++; if (a_q_fwd !== 2'd3) begin n_fail++; $display("FAIL fwd_e2_qfwd: got %0d exp 3", a_q_fwd); end
    n_tests++; if (a_pq !== 4'b1100) begin n_fail++; $display("FAIL fwd_e2_pq: got %b exp 1100", a_pq); end
    n_tests++; if (a_count !== 2'd2 || a_full !== 1'b1)
      begin n_fail++; $display("FAIL fwd_e2_cnt: got count=%0d full=%b exp 2 1", a_count, a_full); end
    a_mode = MODE_HOLD;
  endtask

  task automatic test_load_rev();
    a_mode = MODE_LOAD; a_pdin = {2'b10, 2'b01}; a_pvld = 2'b11;
    tick();
    n_tests++; if (a_q_rev !== 2'd1 || a_count !== 2'd2)
      begin n_fail++; $display("FAIL load_a: got q_rev=%0d count=%0d exp 1 2", a_q_rev, a_count); end
    a_mode = MODE_REV; a_din = 2'd0; a_din_vld = 1'b0;
    tick();
    n_tests++; if (a_q_rev !== 2'd2 || a_pq !== 4'b0010)
      begin n_fail++; $display("FAIL rev_e1: got q_rev=%0d pq=%b exp 2 0010", a_q_rev, a_pq); end
    n_tests++; if (a_count !== 2'd1 || a_vld !== 2'b01)
      begin n_fail++; $display("FAIL rev_e1_cnt: got count=%0d vld=%b exp 1 01", a_count, a_vld); end
    tick();
    n_tests++; if (a_q_rev !== 2'd0 || a_count !== 2'd0 || a_empty !== 1'b1)
      begin n_fail++; $display("FAIL rev_e2: got q_rev=%0d count=%0d empty=%b exp 0 0 1", a_q_rev, a_count, a_empty); end
    a_mode = MODE_HOLD;
  endtask

  task automatic test_saturate();
    b_mode = MODE_FWD; b_din_vld = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      b_din = 4'(k);
      tick();
      n_tests++; if (b_count !== 3'((k < 4) ? k : 4) || b_full !== (k >= 4))
        begin n_fail++; $display("FAIL sat_fill_%0d: got count=%0d full=%b exp %0d %b", k, b_count, b_full, (k < 4) ? k : 4, k >= 4); end
      n_tests++; if (int'(b_count) != pop({12'h0, b_vld}))
        begin n_fail++; $display("FAIL sat_inv_%0d: got count=%0d vld=%b", k, b_count, b_vld); end
    end
    n_tests++; if (b_pq !== 16'h3456 || b_q_fwd !== 4'd3)
      begin n_fail++; $display("FAIL sat_pq: got pq=%h q_fwd=%0d exp 3456 3", b_pq, b_q_fwd); end
    b_din = 4'd0; b_din_vld = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_tests++; if (b_count !== 3'((k < 4) ? 4 - k : 0) || b_empty !== (k >= 4))
        begin n_fail++; $display("FAIL sat_drain_%0d: got count=%0d empty=%b exp %0d %b", k, b_count, b_empty, (k < 4) ? 4 - k : 0, k >= 4); end
    end
    b_mode = MODE_HOLD;
  endtask

  task automatic test_clear();
    a_mode = MODE_LOAD; a_pdin = 4'b1110; a_pvld = 2'b10;
    tick();
    n_tests++; if (a_count !== 2'd1 || a_pq !== 4'b1110)
      begin n_fail++; $display("FAIL clr_pre: got count=%0d pq=%b exp 1 1110", a_count, a_pq); end
    a_clr = 1'b1; a_pdin = 4'hF; a_pvld = 2'b11;
    tick();
    a_clr = 1'b0;
    n_tests++; if (a_pq !== 4'h0 || a_vld !== 2'b00 || a_count !== 2'd0 || a_empty !== 1'b1)
      begin n_fail++; $display("FAIL clr_over_load: got pq=%b vld=%b count=%0d empty=%b exp 0 0 0 1", a_pq, a_vld, a_count, a_empty); end
    a_mode = MODE_FWD; a_din = 2'd1; a_din_vld = 1'b1;
    tick();
    n_tests++; if (a_count !== 2'd1 || a_pq !== 4'b0001)
      begin n_fail++; $display("FAIL rst_pre: got count=%0d pq=%b exp 1 0001", a_count, a_pq); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; a_mode = MODE_HOLD;
    n_tests++; if (a_pq !== 4'h0 || a_count !== 2'd0 || a_empty !== 1'b1)
      begin n_fail++; $display("FAIL rst_mid_fwd: got pq=%b count=%0d empty=%b exp 0 0 1", a_pq, a_count, a_empty); end
  endtask

  task automatic test_hold();
    a_mode = MODE_FWD; a_din = 2'd2; a_din_vld = 1'b1;
    tick();
    a_mode = MODE_HOLD; a_din = 2'd1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++; if (a_pq !== 4'b0010 || a_count !== 2'd1 || a_q_fwd !== 2'd0)
        begin n_fail++; $display("FAIL hold_%0d: got pq=%b count=%0d q_fwd=%0d exp 0010 1 0", k, a_pq, a_count, a_q_fwd); end
    end
    a_mode = MODE_FWD; a_din = 2'd0; a_din_vld = 1'b0;
    tick();
    a_mode = MODE_HOLD;
    n_tests++; if (a_q_fwd !== 2'd2 || a_vld !== 2'b10 || a_count !== 2'd1)
      begin n_fail++; $display("FAIL hold_latency: got q_fwd=%0d vld=%b count=%0d exp 2 10 1", a_q_fwd, a_vld, a_count); end
  endtask

`ifdef SHIFT_PIPE_TAP_EN
  task automatic test_tap();
    b_mode = MODE_LOAD; b_pdin = 16'h3210; b_pvld = 4'hF; b_tap_sel = 2'd0;
    tick();
    n_tests++; if (b_tap_q !== 4'd0 || b_tap_vld !== 1'b1)
      begin n_fail++; $display("FAIL tap_load: got q=%0d vld=%b exp 0 1", b_tap_q, b_tap_vld); end
    b_mode = MODE_HOLD; b_tap_sel = 2'd2;
    tick();
    n_tests++; if (b_tap_q !== 4'd2 || b_tap_vld !== 1'b1)
      begin n_fail++; $display("FAIL tap_sel2: got q=%0d vld=%b exp 2 1", b_tap_q, b_tap_vld); end
    b_mode = MODE_FWD; b_din = 4'd9; b_din_vld = 1'b0; b_tap_sel = 2'd3;
    tick();
    n_tests++; if (b_tap_q !== 4'd2 || b_tap_vld !== 1'b1)
      begin n_fail++; $display("FAIL tap_post_edge: got q=%0d vld=%b exp 2 1", b_tap_q, b_tap_vld); end
    b_mode = MODE_HOLD; b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    n_tests++; if (b_tap_q !== 4'd0 || b_tap_vld !== 1'b0)
      begin n_fail++; $display("FAIL tap_clr: got q=%0d vld=%b exp 0 0", b_tap_q, b_tap_vld); end
    c_mode = MODE_LOAD; c_pdin = 6'b11_10_01; c_pvld = 3'b111; c_tap_sel = 2'd3;
    tick();
    n_tests++; if (c_tap_q !== 2'd0 || c_tap_vld !== 1'b0)
      begin n_fail++; $display("FAIL tap_oor: got q=%0d vld=%b exp 0 0", c_tap_q, c_tap_vld); end
    c_mode = MODE_HOLD; c_tap_sel = 2'd1;
    tick();
    n_tests++; if (c_tap_q !== 2'd2 || c_tap_vld !== 1'b1)
      begin n_fail++; $display("FAIL tap_c_sel1: got q=%0d vld=%b exp 2 1", c_tap_q, c_tap_vld); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    a_clr = 1'b0; a_mode = MODE_HOLD; a_din = '0; a_din_vld = 1'b0; a_pdin = '0; a_pvld = '0;
    b_clr = 1'b0; b_mode = MODE_HOLD; b_din = '0; b_din_vld = 1'b0; b_pdin = '0; b_pvld = '0;
`ifdef SHIFT_PIPE_TAP_EN
    a_tap_sel = '0; b_tap_sel = '0; c_tap_sel = '0;
    c_clr = 1'b0; c_mode = MODE_HOLD; c_din = '0; c_din_vld = 1'b0; c_pdin = '0; c_pvld = '0;
`endif
    #2;
    test_reset();
    test_fwd_latency();
    test_load_rev();
    test_saturate();
    test_clear();
    test_hold();
`ifdef SHIFT_PIPE_TAP_EN
    test_tap();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
